// File: rtl/fwd_pkg.sv
// Shared encodings for the forwarding / hazard unit: operand select codes and
// hazard controller states.
package fwd_pkg;

  typedef enum logic [1:0] {
    FWD_RF     = 2'b00,
    FWD_EXMEM  = 2'b01,
    FWD_MEMWB  = 2'b10,
    FWD_SHADOW = 2'b11
  } fwd_sel_e;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_LOAD_USE = 2'b01,
    ST_MEM_WAIT = 2'b10
  } hz_state_e;

endpackage

// File: rtl/fwd_src_sel.sv
// Forwarding select for one source operand: the youngest matching producer wins,
// and register x0 is never forwarded.
module fwd_src_sel
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs_addr,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_rd_addr,
  input  logic                      exmem_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] memwb_rd_addr,
  input  logic                      memwb_reg_write,
  input  logic                      shadow_vld,
  input  logic [REG_ADDR_WIDTH-1:0] shadow_addr,
  output logic [1:0]                sel
);

  logic rs_nz;

  assign rs_nz = (rs_addr != '0);

  always_comb begin
    sel = FWD_RF;
    if (rs_nz && exmem_reg_write && (rs_addr == exmem_rd_addr))
      sel = FWD_EXMEM;
    else if (rs_nz && memwb_reg_write && (rs_addr == memwb_rd_addr))
      sel = FWD_MEMWB;
    else if (rs_nz && shadow_vld && (rs_addr == shadow_addr))
      sel = FWD_SHADOW;
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding plus load-use / memory-wait stall control for a 5-stage
// pipeline, with a shadow copy of the last WB write for use across freezes.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_SRC        = 2,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0] ifid_rs_addr,
  input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0] idex_rs_addr,
  input  logic [REG_ADDR_WIDTH-1:0]         idex_rd_addr,
  input  logic                              idex_mem_read,
  input  logic [REG_ADDR_WIDTH-1:0]         exmem_rd_addr,
  input  logic                              exmem_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0]         memwb_rd_addr,
  input  logic                              memwb_reg_write,
  input  logic [DATA_WIDTH-1:0]             memwb_rd_data,
  input  logic                              mem_busy,
  input  logic                              mem_ack,
  input  logic                              cnt_clr,
  output logic [2*NUM_SRC-1:0]              fwd_sel,
  output logic [DATA_WIDTH-1:0]             shadow_data,
  output logic                              stall_if,
  output logic                              stall_id,
  output logic                              bubble_ex,
  output logic                              hold_all,
  output logic [CNT_WIDTH-1:0]              stall_cycles
);

  hz_state_e                 state, state_nxt;
  logic                      shadow_vld;
  logic [REG_ADDR_WIDTH-1:0] shadow_addr;
  logic [2*NUM_SRC-1:0]      sel_raw;
  logic                      load_use;
  logic                      mem_req;
  logic                      hold_c, stall_c, bubble_c;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    fwd_src_sel #(
      .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_sel (
      .rs_addr         (idex_rs_addr[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]),
      .exmem_rd_addr   (exmem_rd_addr),
      .exmem_reg_write (exmem_reg_write),
      .memwb_rd_addr   (memwb_rd_addr),
      .memwb_reg_write (memwb_reg_write),
      .shadow_vld      (shadow_vld),
      .shadow_addr     (shadow_addr),
      .sel             (sel_raw[2*k +: 2])
    );
  end

  always_comb begin
    load_use = 1'b0;
    if (idex_mem_read && (idex_rd_addr != '0)) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (ifid_rs_addr[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == idex_rd_addr)
          load_use = 1'b1;
      end
    end
  end

  assign mem_req = mem_busy & ~mem_ack;

  // Memory wait outranks load-use; the cycle after a load-use bubble ignores load_use.
  always_comb begin
    state_nxt = state;
    hold_c    = 1'b0;
    stall_c   = 1'b0;
    bubble_c  = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (mem_req) begin
          hold_c    = 1'b1;
          state_nxt = ST_MEM_WAIT;
        end else if (load_use) begin
          stall_c   = 1'b1;
          bubble_c  = 1'b1;
          state_nxt = ST_LOAD_USE;
        end
      end
      ST_LOAD_USE: begin
        if (mem_req) begin
          hold_c    = 1'b1;
          state_nxt = ST_MEM_WAIT;
        end else begin
          state_nxt = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        if (!mem_ack) hold_c = 1'b1;
        else          state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_RUN;
    else       state <= state_nxt;
  end

  // Outputs are gated by reset so they drop immediately, even mid-stall.
  assign hold_all  = hold_c & ~rst_i;
  assign stall_if  = (hold_c | stall_c) & ~rst_i;
  assign stall_id  = (hold_c | stall_c) & ~rst_i;
  assign bubble_ex = bubble_c & ~hold_c & ~rst_i;
  assign fwd_sel   = rst_i ? '0 : sel_raw;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shadow_vld  <= 1'b0;
      shadow_addr <= '0;
      shadow_data <= '0;
    end else if (!hold_c) begin
      if (memwb_reg_write && (memwb_rd_addr != '0)) begin
        shadow_vld  <= 1'b1;
        shadow_addr <= memwb_rd_addr;
        shadow_data <= memwb_rd_data;
      end else begin
        shadow_vld  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      stall_cycles <= '0;
    else if (cnt_clr)
      stall_cycles <= '0;
    else if (stall_if && (stall_cycles != '1))
      stall_cycles <= stall_cycles + CNT_WIDTH'(1);
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: a flag-based behavioural model checked every
// cycle, plus hand-computed literal expectations for the key scenarios.
module tb_fwd_hazard_unit;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NS = 2;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [NS*AW-1:0] ifid_rs_addr, idex_rs_addr;
  logic [AW-1:0] idex_rd_addr, exmem_rd_addr, memwb_rd_addr;
  logic          idex_mem_read, exmem_reg_write, memwb_reg_write;
  logic          mem_busy, mem_ack, cnt_clr;
  logic [DW-1:0] memwb_rd_data;

  logic [2*NS-1:0] fwd_sel, fwd_sel2;
  logic [DW-1:0]   shadow_data, shadow_data2;
  logic            stall_if, stall_id, bubble_ex, hold_all;
  logic            stall_if2, stall_id2, bubble_ex2, hold_all2;
  logic [CW-1:0]   stall_cycles;
  logic [1:0]      stall_cycles2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .NUM_SRC(NS), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_i(rst_i), .ifid_rs_addr(ifid_rs_addr), .idex_rs_addr(idex_rs_addr),
    .idex_rd_addr(idex_rd_addr), .idex_mem_read(idex_mem_read),
    .exmem_rd_addr(exmem_rd_addr), .exmem_reg_write(exmem_reg_write),
    .memwb_rd_addr(memwb_rd_addr), .memwb_reg_write(memwb_reg_write),
    .memwb_rd_data(memwb_rd_data), .mem_busy(mem_busy), .mem_ack(mem_ack),
    .cnt_clr(cnt_clr), .fwd_sel(fwd_sel), .shadow_data(shadow_data),
    .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
    .hold_all(hold_all), .stall_cycles(stall_cycles));

  fwd_hazard_unit #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .NUM_SRC(NS), .CNT_WIDTH(2)) dut_c2 (
    .clk_i(clk), .rst_i(rst_i), .ifid_rs_addr(ifid_rs_addr), .idex_rs_addr(idex_rs_addr),
    .idex_rd_addr(idex_rd_addr), .idex_mem_read(idex_mem_read),
    .exmem_rd_addr(exmem_rd_addr), .exmem_reg_write(exmem_reg_write),
    .memwb_rd_addr(memwb_rd_addr), .memwb_reg_write(memwb_reg_write),
    .memwb_rd_data(memwb_rd_data), .mem_busy(mem_busy), .mem_ack(mem_ack),
    .cnt_clr(cnt_clr), .fwd_sel(fwd_sel2), .shadow_data(shadow_data2),
    .stall_if(stall_if2), .stall_id(stall_id2), .bubble_ex(bubble_ex2),
    .hold_all(hold_all2), .stall_cycles(stall_cycles2));

  // Behavioural model: "waiting on memory" and "just bubbled" flags, a shadow copy, counters.
  bit            m_wait, m_cool, m_sh_vld;
  logic [AW-1:0] m_sh_addr;
  logic [DW-1:0] m_sh_data;
  int            m_cnt, m_cnt2;
  bit            e_hold, e_stall, e_bub;
  logic [2*NS-1:0] e_sel;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] model_sel(input logic [AW-1:0] rs);
    if (rs == 0) return 2'b00;
    if (exmem_reg_write && rs == exmem_rd_addr) return 2'b01;
    if (memwb_reg_write && rs == memwb_rd_addr) return 2'b10;
    if (m_sh_vld && rs == m_sh_addr) return 2'b11;
    return 2'b00;
  endfunction

  task automatic eval();
    bit lu;
    lu = 0;
    if (idex_mem_read && idex_rd_addr != 0)
      for (int k = 0; k < NS; k++)
        if (ifid_rs_addr[k*AW +: AW] == idex_rd_addr) lu = 1;
    e_hold = 0; e_stall = 0; e_bub = 0;
    if (m_wait) e_hold = !mem_ack;
    else if (mem_busy && !mem_ack) e_hold = 1;
    else if (!m_cool && lu) begin e_stall = 1; e_bub = 1; end
    if (e_hold) e_stall = 1;
    for (int k = 0; k < NS; k++) e_sel[2*k +: 2] = model_sel(idex_rs_addr[k*AW +: AW]);
  endtask

  initial forever begin
    @(posedge clk or posedge rst_i);
    if (rst_i) begin
      m_wait = 0; m_cool = 0; m_sh_vld = 0; m_sh_addr = 0; m_sh_data = 0;
      m_cnt = 0; m_cnt2 = 0;
    end else begin
      eval();
      if (!e_hold) begin
        if (memwb_reg_write && memwb_rd_addr != 0) begin
          m_sh_vld = 1; m_sh_addr = memwb_rd_addr; m_sh_data = memwb_rd_data;
        end else m_sh_vld = 0;
      end
      if (cnt_clr) begin m_cnt = 0; m_cnt2 = 0; end
      else if (e_stall) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      m_wait = e_hold;
      m_cool = e_bub;
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_i) begin
      check("rst_fwd_sel", fwd_sel, 0);
      check("rst_hold_all", hold_all, 0);
      check("rst_stall_if", stall_if, 0);
      check("rst_shadow", shadow_data, 0);
      check("rst_cnt", stall_cycles, 0);
    end else begin
      eval();
      check("m_fwd_sel", fwd_sel, e_sel);
      check("m_fwd_sel2", fwd_sel2, e_sel);
      check("m_hold_all", {hold_all, hold_all2}, {e_hold, e_hold});
      check("m_stall_if", {stall_if, stall_if2}, {e_stall, e_stall});
      check("m_stall_id", {stall_id, stall_id2}, {e_stall, e_stall});
      check("m_bubble_ex", {bubble_ex, bubble_ex2}, {e_bub, e_bub});
      check("m_shadow", shadow_data, m_sh_data);
      check("m_shadow2", shadow_data2, m_sh_data);
      check("m_cnt", stall_cycles, m_cnt);
      check("m_cnt2", stall_cycles2, m_cnt2);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifid_rs_addr = 0; idex_rs_addr = 0; idex_rd_addr = 0; idex_mem_read = 0;
    exmem_rd_addr = 0; exmem_reg_write = 0; memwb_rd_addr = 0; memwb_reg_write = 0;
    memwb_rd_data = 0; mem_busy = 0; mem_ack = 0; cnt_clr = 0;
  endtask

  task automatic set_load_use();
    idex_mem_read = 1; idex_rd_addr = 5'd7; ifid_rs_addr = {5'd0, 5'd7};
  endtask

  initial begin
    int nhold;
    rst_i = 1;
    idle();
    tick(); tick();
    rst_i = 0;

    // Both later stages write x5: EX/MEM is younger
    exmem_reg_write = 1; exmem_rd_addr = 5'd5;
    memwb_reg_write = 1; memwb_rd_addr = 5'd5; memwb_rd_data = 32'h1111_0005;
    idex_rs_addr = {5'd3, 5'd5};
    @(negedge clk);
    check("exmem_wins", fwd_sel[1:0], 2'b01);
    check("rs2_nomatch", fwd_sel[3:2], 2'b00);
    tick();

    // x0 never forwarded
    idle();
    exmem_reg_write = 1; exmem_rd_addr = 5'd0; idex_rs_addr = {5'd0, 5'd0};
    @(negedge clk);
    check("x0_no_fwd", fwd_sel[3:2], 2'b00);
    tick();

    // Mixed: rs1 from MEM/WB, rs2 from EX/MEM
    idle();
    exmem_reg_write = 1; exmem_rd_addr = 5'd4;
    memwb_reg_write = 1; memwb_rd_addr = 5'd6; memwb_rd_data = 32'h6;
    idex_rs_addr = {5'd4, 5'd6};
    @(negedge clk);
    check("mixed_sel", fwd_sel, 4'b0110);
    tick();

    // Load-use: one bubble cycle, then the cooldown cycle ignores load_use
    idle(); cnt_clr = 1;
    tick();
    idle(); set_load_use();
    @(negedge clk);
    check("lu_stall", {stall_if, stall_id, bubble_ex}, 3'b111);
    tick();
    @(negedge clk);
    check("lu_release", {stall_if, stall_id, bubble_ex, hold_all}, 4'b0000);
    check("lu_cnt", stall_cycles, 1);
    tick();
    idle();
    tick();

    // Memory wait with simultaneous load-use: hold only, bubble after return
    set_load_use(); mem_busy = 1; mem_ack = 0;
    nhold = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (hold_all) nhold++;
      check("mw_no_bubble", bubble_ex, 0);
      tick();
    end
    mem_busy = 0; mem_ack = 1;
    @(negedge clk);
    check("mw_hold_count", nhold, 3);
    check("mw_ack_cycle", {hold_all, stall_if, bubble_ex}, 3'b000);
    tick();
    mem_ack = 0;
    @(negedge clk);
    check("mw_lu_after", bubble_ex, 1);
    tick();
    idle();
    tick(); tick();

    // Shadow: WB writes x9, then the pipeline freezes
    memwb_reg_write = 1; memwb_rd_addr = 5'd9; memwb_rd_data = 32'hDEADBEEF;
    tick();
    idle(); mem_busy = 1; idex_rs_addr = {5'd0, 5'd9};
    @(negedge clk);
    check("sh_hold", hold_all, 1);
    check("sh_sel", fwd_sel[1:0], 2'b11);
    check("sh_data", shadow_data, 32'hDEADBEEF);
    tick();
    mem_busy = 0; mem_ack = 1;
    @(negedge clk);
    check("sh_sel_held", fwd_sel[1:0], 2'b11);
    tick();
    mem_ack = 0;
    @(negedge clk);
    check("sh_cleared", fwd_sel[1:0], 2'b00);
    tick();

    // Asynchronous reset during MEM_WAIT
    idle(); mem_busy = 1;
    tick();
    @(negedge clk);
    check("ar_pre_hold", hold_all, 1);
    #1 rst_i = 1;
    #1;
    check("ar_hold_drop", hold_all, 0);
    check("ar_stall_drop", {stall_if, stall_id}, 2'b00);
    check("ar_cnt_zero", stall_cycles, 0);
    check("ar_shadow_zero", shadow_data, 0);
    @(posedge clk);
    #1 rst_i = 0;
    idle();

    // Five stall cycles: 2-bit counter saturates at 3
    mem_busy = 1;
    for (int i = 0; i < 5; i++) tick();
    mem_busy = 0; mem_ack = 1;
    @(negedge clk);
    check("sat_cnt2", stall_cycles2, 2'd3);
    check("sat_cnt16", stall_cycles, 16'd5);
    tick();

    // Clear wins over increment during a stall
    idle(); set_load_use(); cnt_clr = 1;
    @(negedge clk);
    check("clr_stall_on", stall_if, 1);
    tick();
    idle();
    @(negedge clk);
    check("clr_wins", stall_cycles, 0);
    check("clr_wins2", stall_cycles2, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, register data width.
REQ-002 Parameter REG_ADDR_WIDTH, default 5, register address width.
REQ-003 Parameter NUM_SRC, default 2, number of source operands per instruction.
REQ-004 Parameter CNT_WIDTH, default 16, stall-cycle counter width.
REQ-005 The block SHALL use one clock and an asynchronous, active-high reset, with ports as follows:
REQ-006 clk_i  in  1  clock; all state updates on rising edge.
REQ-007 rst_i  in  1  asynchronous active-high reset.
REQ-008 ifid_rs_addr  in  NUM_SRC*REG_ADDR_WIDTH  source addresses of instruction in ID (source k at slice k).
REQ-009 idex_rs_addr  in  NUM_SRC*REG_ADDR_WIDTH  source addresses of instruction in EX.
REQ-010 idex_rd_addr  in  REG_ADDR_WIDTH  destination of instruction in EX.
REQ-011 idex_mem_read  in  1  instruction in EX is a load.
REQ-012 exmem_rd_addr  in  REG_ADDR_WIDTH;  exmem_reg_write  in  1  MEM-stage destination and write enable.
REQ-013 memwb_rd_addr  in  REG_ADDR_WIDTH;  memwb_reg_write  in  1;  memwb_rd_data  in  DATA_WIDTH  WB-stage destination, enable, data.
REQ-014 mem_busy  in  1  data-memory request outstanding;  mem_ack  in  1  data-memory request completes this cycle.
REQ-015 cnt_clr  in  1  synchronous clear of stall counter.
REQ-016 fwd_sel  out  2*NUM_SRC  per-source select: 00 regfile, 01 EX/MEM, 10 MEM/WB, 11 shadow.
REQ-017 shadow_data  out  DATA_WIDTH  shadow register value for select 11.
REQ-018 stall_if, stall_id  out  1 each  hold PC / IF-ID register;  bubble_ex  out  1  insert NOP into ID/EX;  hold_all  out  1  freeze all pipeline registers.
REQ-019 stall_cycles  out  CNT_WIDTH  count of cycles with stall_if asserted.

Function
REQ-020 Per source k: select 01 if exmem_reg_write, rs!=0, rs==exmem_rd_addr; else 10 if memwb match under same rules; else 11 if shadow valid, rs!=0, rs==shadow address; else 00 (youngest producer wins).
REQ-021 fwd_sel SHALL be combinational from idex_rs_addr and current pipeline/shadow state (zero latency).
REQ-022 Shadow SHALL capture memwb_rd_addr/memwb_rd_data and set valid on each edge where memwb_reg_write=1, memwb_rd_addr!=0, hold_all=0; otherwise valid clears on the next edge unless hold_all=1 (holds).
REQ-023 load_use = idex_mem_read & idex_rd_addr!=0 & idex_rd_addr equals any ifid_rs_addr slice.
REQ-024 FSM states RUN, LOAD_USE, MEM_WAIT; reset state RUN.
REQ-025 RUN: mem_busy=1 & mem_ack=0 -> hold_all=1, next MEM_WAIT; else load_use -> stall_if=stall_id=bubble_ex=1, next LOAD_USE; else all stalls 0, stay RUN.
REQ-026 LOAD_USE: stalls 0 for exactly one cycle, load_use ignored; next MEM_WAIT if mem_busy & !mem_ack (hold_all=1), else RUN.
REQ-027 MEM_WAIT: hold_all=stall_if=stall_id=1 while mem_ack=0; in mem_ack cycle all stalls 0, next RUN.
REQ-028 mem_busy SHALL take priority over load_use in the same cycle; load_use re-evaluated after return to RUN.
REQ-029 hold_all=1 SHALL force stall_if=stall_id=1 and bubble_ex=0.
REQ-030 stall_cycles SHALL increment each cycle stall_if=1, saturate at 2^CNT_WIDTH-1, and cnt_clr SHALL win over increment (value 0 next cycle).

Reset
REQ-031 rst_i SHALL immediately set state RUN, shadow valid 0, shadow address/data 0, stall_cycles 0; all stall outputs 0, fwd_sel all 00, shadow_data 0 during reset, including mid-stall.

Structure
REQ-032 Package fwd_pkg SHALL hold the fwd_sel encoding enum and FSM state enum.
REQ-033 Sub-module fwd_src_sel (one source's priority match) SHALL be instantiated NUM_SRC times via generate.

Verification
REQ-034 EX/MEM and MEM/WB both write x5, idex rs1=5 -> fwd_sel[1:0]=01.
REQ-035 idex rs2=0 while exmem_rd_addr=0, exmem_reg_write=1 -> fwd_sel[3:2]=00.
REQ-036 Load to x7 in EX, ifid rs1=7 -> one cycle stall_if=stall_id=bubble_ex=1, then 0; stall_cycles=1.
REQ-037 mem_busy high 3 cycles, mem_ack on 4th, simultaneous load_use -> hold_all=1 for 3 cycles, 0 on ack cycle, no bubble_ex during hold.
REQ-038 WB writes x9=0xDEADBEEF with hold_all=1 next cycle, idex rs1=9, no other match -> fwd_sel=11, shadow_data=0xDEADBEEF.
REQ-039 rst_i asserted in MEM_WAIT -> hold_all drops without clock edge; CNT_WIDTH=2 with 5 stall cycles -> stall_cycles=3.
